axi_burst_mem_slave: RTL and testbench

- AXI4 memory-mapped slave backed by an on-chip word array.
- Accepts INCR/FIXED write and read bursts from an AXI4 master and returns B/R responses.
- Serves as the responder end for the block's M_AXI burst master, in hardware and in example designs.
- One outstanding write and one outstanding read; the read and write paths are independent.

---
 rtl/axi_burst_mem_pkg.sv | 32 +++
 rtl/axi_burst_mem_slave_if.sv | 66 ++++++
 rtl/axi_burst_mem_array.sv | 27 ++
 rtl/axi_burst_mem_slave.sv | 221 ++++++++++++++++++++++
 tb/tb_axi_burst_mem_slave.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_burst_mem_pkg.sv
// Shared response/burst codes and FSM state types for the AXI4 burst memory slave.
package axi_burst_mem_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  // Only FIXED and INCR are served; anything else completes with SLVERR.
  function automatic logic burst_ok(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_burst_mem_slave_if.sv
// AXI4 full-width burst bus (no SIZE/LOCK/CACHE/PROT/QOS/USER) between a master and the memory slave.
interface axi_burst_mem_slave_if #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32
);

  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [7:0]                      S_AXI_AWLEN;
  logic [1:0]                      S_AXI_AWBURST;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;

  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WLAST;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;

  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;

  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [7:0]                      S_AXI_ARLEN;
  logic [1:0]                      S_AXI_ARBURST;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;

  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RLAST;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    output S_AXI_RREADY
  );

endinterface

// File: rtl/axi_burst_mem_array.sv
// MEM_WORDS x 32 word array: byte-enabled synchronous write, asynchronous read (old data on collision).
module axi_burst_mem_array #(
  parameter  int MEM_WORDS = 64,
  localparam int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       wstrb,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_burst_mem_slave.sv
// AXI4 burst memory slave: one outstanding write and one outstanding read on independent FSMs.
module axi_burst_mem_slave
  import axi_burst_mem_pkg::*;
#(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int MEM_WORDS          = 64
) (
  input logic                  ACLK,
  input logic                  ARESETN,
  axi_burst_mem_slave_if.slave s_axi
);

  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  typedef logic [IDX_W-1:0] idx_t;

  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [C_S_AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [STRB_W-1:0]             w_strb;
  logic                          unused_addr_bits;

  assign aw_addr          = s_axi.S_AXI_AWADDR;
  assign ar_addr          = s_axi.S_AXI_ARADDR;
  assign w_strb           = s_axi.S_AXI_WSTRB;
  assign unused_addr_bits = ^{aw_addr, ar_addr};

  // ---------------- write path ----------------
  wr_state_t                   w_state;
  logic                        awready_q;
  logic                        wready_q;
  logic                        bvalid_q;
  logic [1:0]                  bresp_q;
  logic [C_S_AXI_ID_WIDTH-1:0] bid_q;
  idx_t                        w_idx;
  logic [7:0]                  w_cnt;
  logic [7:0]                  w_len;
  logic                        w_fixed;
  logic                        w_bad;
  logic                        w_wlast_err;

  logic aw_fire;
  logic w_fire;
  logic w_final;
  logic wlast_mismatch;

  assign aw_fire        = awready_q & s_axi.S_AXI_AWVALID;
  assign w_fire         = wready_q & s_axi.S_AXI_WVALID;
  assign w_final        = (w_cnt == w_len);
  assign wlast_mismatch = s_axi.S_AXI_WLAST != w_final;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_state     <= W_IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      bid_q       <= '0;
      w_idx       <= '0;
      w_cnt       <= '0;
      w_len       <= '0;
      w_fixed     <= 1'b0;
      w_bad       <= 1'b0;
      w_wlast_err <= 1'b0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (aw_fire) begin
            awready_q   <= 1'b0;
            wready_q    <= 1'b1;
            bid_q       <= s_axi.S_AXI_AWID;
            w_idx       <= aw_addr[IDX_W+1:2];
            w_cnt       <= '0;
            w_len       <= s_axi.S_AXI_AWLEN;
            w_fixed     <= s_axi.S_AXI_AWBURST == BURST_FIXED;
            w_bad       <= !burst_ok(s_axi.S_AXI_AWBURST);
            w_wlast_err <= 1'b0;
            w_state     <= W_DATA;
          end else begin
            awready_q <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_cnt <= w_cnt + 8'd1;
            if (!w_fixed) w_idx <= w_idx + idx_t'(1);
            // The beat counter alone ends the burst; WLAST only feeds the response.
            if (w_final) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (w_bad || w_wlast_err || wlast_mismatch) ? RESP_SLVERR : RESP_OKAY;
              w_state  <= W_RESP;
            end else if (wlast_mismatch) begin
              w_wlast_err <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (s_axi.S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  rd_state_t                   r_state;
  logic                        arready_q;
  logic                        rvalid_q;
  logic                        rlast_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]                  rresp_q;
  logic [C_S_AXI_ID_WIDTH-1:0] rid_q;
  idx_t                        r_idx;
  logic [7:0]                  r_cnt;
  logic [7:0]                  r_len;
  logic                        r_fixed;
  logic                        r_bad;

  logic                          ar_fire;
  logic                          r_fire;
  logic                          ar_ok;
  idx_t                          rd_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;

  assign ar_fire = arready_q & s_axi.S_AXI_ARVALID;
  assign r_fire  = rvalid_q & s_axi.S_AXI_RREADY;
  assign ar_ok   = burst_ok(s_axi.S_AXI_ARBURST);

  // In idle the fetch comes straight from ARADDR so the first beat is ready one cycle after AR.
  always_comb begin
    rd_idx = r_idx;
    if (r_state == R_IDLE) rd_idx = ar_addr[IDX_W+1:2];
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rid_q     <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_len     <= '0;
      r_fixed   <= 1'b0;
      r_bad     <= 1'b0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (ar_fire) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rid_q     <= s_axi.S_AXI_ARID;
            r_len     <= s_axi.S_AXI_ARLEN;
            r_cnt     <= '0;
            rlast_q   <= s_axi.S_AXI_ARLEN == 8'd0;
            r_fixed   <= s_axi.S_AXI_ARBURST == BURST_FIXED;
            r_bad     <= !ar_ok;
            rresp_q   <= ar_ok ? RESP_OKAY : RESP_SLVERR;
            rdata_q   <= ar_ok ? rd_word : '0;
            r_idx     <= (s_axi.S_AXI_ARBURST == BURST_FIXED) ? rd_idx : rd_idx + idx_t'(1);
            r_state   <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_fire) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state   <= R_IDLE;
            end else begin
              rdata_q <= r_bad ? '0 : rd_word;
              r_cnt   <= r_cnt + 8'd1;
              rlast_q <= (r_cnt + 8'd1) == r_len;
              if (!r_fixed) r_idx <= r_idx + idx_t'(1);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  axi_burst_mem_array #(
    .MEM_WORDS (MEM_WORDS)
  ) u_array (
    .clk   (ACLK),
    .we    (w_fire & ~w_bad),
    .wstrb (w_strb),
    .waddr (w_idx),
    .wdata (s_axi.S_AXI_WDATA),
    .raddr (rd_idx),
    .rdata (rd_word)
  );

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_BID     = bid_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RLAST   = rlast_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RID     = rid_q;

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Directed and randomized bursts against a word-array reference model of the AXI4 memory slave.
module tb_axi_burst_mem_slave;

  localparam int IDW = 1;
  localparam int AW  = 32;
  localparam int MW  = 64;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi_burst_mem_slave_if #(
    .C_S_AXI_ID_WIDTH   (IDW),
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (AW)
  ) bus ();

  axi_burst_mem_slave #(
    .C_S_AXI_ID_WIDTH   (IDW),
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (AW),
    .MEM_WORDS          (MW)
  ) dut (
    .ACLK    (clk),
    .ARESETN (rstn),
    .s_axi   (bus)
  );

  logic [31:0] model [MW];
  logic [31:0] got[$];
  logic [31:0] dq[$];
  logic [3:0]  sq[$];
  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // Word touched by a given beat: INCR steps by one word modulo the depth, FIXED never moves.
  function automatic int widx(input logic [31:0] a, input int beat, input logic [1:0] bt);
    int base;
    base = int'(a[31:2]) % MW;
    return (bt == 2'b00) ? base : (base + beat) % MW;
  endfunction

  task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] bt,
                          input logic [IDW-1:0] id, input logic [31:0] d[$],
                          input logic [3:0] s[$], input int last_at);
    int n;
    int k;
    int w;
    logic [1:0] want_resp;
    want_resp = (bt > 2'd1 || last_at != len) ? 2'b10 : 2'b00;
    bus.S_AXI_AWID    = id;
    bus.S_AXI_AWADDR  = addr;
    bus.S_AXI_AWLEN   = 8'(len);
    bus.S_AXI_AWBURST = bt;
    bus.S_AXI_AWVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_AWREADY && n < 20) begin tick(); n++; end
    check("awready", 32'(bus.S_AXI_AWREADY), 32'd1);
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    check("wready_after_aw", 32'(bus.S_AXI_WREADY), 32'd1);
    for (int i = 0; i <= len; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.S_AXI_WVALID = 1'b0;
        tick();
      end
      bus.S_AXI_WDATA  = d[i];
      bus.S_AXI_WSTRB  = s[i];
      bus.S_AXI_WLAST  = (i == last_at);
      bus.S_AXI_WVALID = 1'b1;
      n = 0;
      while (!bus.S_AXI_WREADY && n < 20) begin tick(); n++; end
      check("wready_beat", 32'(bus.S_AXI_WREADY), 32'd1);
      if (bt <= 2'd1) begin
        w = widx(addr, i, bt);
        for (int b = 0; b < 4; b++)
          if (s[i][b]) model[w][8*b +: 8] = d[i][8*b +: 8];
      end
      tick();
    end
    bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_WLAST  = 1'b0;
    check("wready_done", 32'(bus.S_AXI_WREADY), 32'd0);
    check("bvalid_latency", 32'(bus.S_AXI_BVALID), 32'd1);
    k = $urandom_range(0, 2);
    repeat (k) begin
      check("bvalid_hold", 32'(bus.S_AXI_BVALID), 32'd1);
      check("bresp_hold", 32'(bus.S_AXI_BRESP), 32'(want_resp));
      tick();
    end
    check("bresp", 32'(bus.S_AXI_BRESP), 32'(want_resp));
    check("bid", 32'(bus.S_AXI_BID), 32'(id));
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    check("bvalid_clear", 32'(bus.S_AXI_BVALID), 32'd0);
    check("awready_after_b", 32'(bus.S_AXI_AWREADY), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] bt,
                         input logic [IDW-1:0] id, input bit rand_ready, input int abort_at);
    logic [31:0] want[$];
    logic [1:0]  want_resp;
    int b;
    int n;
    got.delete();
    want_resp = (bt > 2'd1) ? 2'b10 : 2'b00;
    for (int i = 0; i <= len; i++) want.push_back((bt > 2'd1) ? 32'd0 : model[widx(addr, i, bt)]);
    bus.S_AXI_ARID    = id;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARLEN   = 8'(len);
    bus.S_AXI_ARBURST = bt;
    bus.S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < 20) begin tick(); n++; end
    check("arready", 32'(bus.S_AXI_ARREADY), 32'd1);
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    b = 0;
    n = 0;
    while (b <= len && n < 400) begin
      if (b == abort_at) begin
        rstn = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        tick();
        check("rst_rvalid", 32'(bus.S_AXI_RVALID), 32'd0);
        check("rst_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
        check("rst_rdata", bus.S_AXI_RDATA, 32'd0);
        rstn = 1'b1;
        tick();
        check("rst_arready_after", 32'(bus.S_AXI_ARREADY), 32'd1);
        check("rst_awready_after", 32'(bus.S_AXI_AWREADY), 32'd1);
        check("rst_rvalid_after", 32'(bus.S_AXI_RVALID), 32'd0);
        return;
      end
      bus.S_AXI_RREADY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      check("rvalid", 32'(bus.S_AXI_RVALID), 32'd1);
      check("rdata", bus.S_AXI_RDATA, want[b]);
      check("rresp", 32'(bus.S_AXI_RRESP), 32'(want_resp));
      check("rlast", 32'(bus.S_AXI_RLAST), 32'(b == len));
      check("rid", 32'(bus.S_AXI_RID), 32'(id));
      if (bus.S_AXI_RREADY && bus.S_AXI_RVALID) got.push_back(bus.S_AXI_RDATA);
      tick();
      n++;
      if (bus.S_AXI_RREADY) b++;
    end
    bus.S_AXI_RREADY = 1'b0;
    check("rvalid_after_last", 32'(bus.S_AXI_RVALID), 32'd0);
    check("arready_after_last", 32'(bus.S_AXI_ARREADY), 32'd1);
  endtask

  task automatic fill(input int n, input logic [3:0] strb);
    dq.delete();
    sq.delete();
    for (int i = 0; i < n; i++) begin
      dq.push_back($urandom());
      sq.push_back(strb);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    int rl;
    logic [1:0] rb;
    bus.S_AXI_AWID = '0;  bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0;
    bus.S_AXI_AWBURST = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARID = '0;  bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = '0;
    bus.S_AXI_ARBURST = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;

    rstn = 1'b0;
    tick();
    tick();
    check("reset_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
    check("reset_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
    check("reset_wready", 32'(bus.S_AXI_WREADY), 32'd0);
    check("reset_bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
    check("reset_rvalid", 32'(bus.S_AXI_RVALID), 32'd0);
    check("reset_bresp", 32'(bus.S_AXI_BRESP), 32'd0);
    check("reset_rresp", 32'(bus.S_AXI_RRESP), 32'd0);
    check("reset_rdata", bus.S_AXI_RDATA, 32'd0);
    check("reset_bid", 32'(bus.S_AXI_BID), 32'd0);
    check("reset_rid", 32'(bus.S_AXI_RID), 32'd0);
    check("reset_rlast", 32'(bus.S_AXI_RLAST), 32'd0);
    rstn = 1'b1;
    tick();
    check("post_reset_awready", 32'(bus.S_AXI_AWREADY), 32'd1);
    check("post_reset_arready", 32'(bus.S_AXI_ARREADY), 32'd1);

    // Known contents everywhere so later reads have defined expectations.
    fill(MW, 4'hF);
    do_write(32'h0, MW - 1, 2'b01, 1'b0, dq, sq, MW - 1);

    // 1: INCR 8 beats, data 1..8
    dq.delete(); sq.delete();
    for (int i = 0; i < 8; i++) begin dq.push_back(32'(i + 1)); sq.push_back(4'hF); end
    do_write(32'h0, 7, 2'b01, 1'b1, dq, sq, 7);
    do_read(32'h0, 7, 2'b01, 1'b1, 1'b0, -1);
    check("t1_beats", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8; i++) check("t1_data", got[i], 32'(i + 1));

    // 2: partial strobes
    dq = '{32'hFFFF_FFFF}; sq = '{4'hF};
    do_write(32'h10, 0, 2'b01, 1'b0, dq, sq, 0);
    dq = '{32'h0}; sq = '{4'b0011};
    do_write(32'h10, 0, 2'b01, 1'b1, dq, sq, 0);
    do_read(32'h10, 0, 2'b01, 1'b0, 1'b0, -1);
    check("t2_strb", got[0], 32'hFFFF_0000);

    // 3: INCR wraps past the top of the array; FIXED read stays on one word
    dq = '{32'hA, 32'hB, 32'hC, 32'hD}; sq = '{4'hF, 4'hF, 4'hF, 4'hF};
    do_write(32'hF8, 3, 2'b01, 1'b0, dq, sq, 3);
    do_read(32'hF8, 3, 2'b01, 1'b0, 1'b0, -1);
    for (int i = 0; i < 4; i++) check("t3_incr_wrap", got[i], 32'(10 + i));
    do_read(32'hF8, 3, 2'b00, 1'b1, 1'b0, -1);
    for (int i = 0; i < 4; i++) check("t3_fixed", got[i], 32'hA);

    // 4: WRAP write discarded; misplaced/missing WLAST consumes all beats but errors
    fill(4, 4'hF);
    do_write(32'h40, 3, 2'b10, 1'b1, dq, sq, 3);
    do_read(32'h40, 3, 2'b01, 1'b0, 1'b0, -1);
    fill(4, 4'hF);
    do_write(32'h80, 3, 2'b01, 1'b0, dq, sq, 1);
    fill(4, 4'hF);
    do_write(32'h60, 3, 2'b01, 1'b1, dq, sq, -1);
    do_read(32'h60, 7, 2'b01, 1'b1, 1'b0, -1);
    do_read(32'h20, 2, 2'b10, 1'b0, 1'b0, -1);

    // 5: stalled 16-beat read concurrent with an unrelated write burst
    fill(8, 4'hF);
    fork
      do_read(32'h0, 15, 2'b01, 1'b1, 1'b1, -1);
      do_write(32'h80, 7, 2'b01, 1'b0, dq, sq, 7);
    join
    check("t5_beats", 32'(got.size()), 32'd16);
    do_read(32'h80, 7, 2'b01, 1'b0, 1'b1, -1);

    // 6: reset during beat 3 of an 8-beat read, then a clean read
    do_read(32'h0, 7, 2'b01, 1'b1, 1'b0, 2);
    do_read(32'h0, 7, 2'b01, 1'b0, 1'b0, -1);
    check("t6_beats", 32'(got.size()), 32'd8);

    // Randomized bursts checked against the model.
    repeat (10) begin
      rl = $urandom_range(0, 7);
      rb = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      dq.delete(); sq.delete();
      for (int i = 0; i <= rl; i++) begin dq.push_back($urandom()); sq.push_back(4'($urandom())); end
      ra = $urandom();
      do_write(ra, rl, rb, 1'($urandom()), dq, sq, ($urandom_range(0, 5) == 0) ? 0 : rl);
      rl = $urandom_range(0, 9);
      rb = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      do_read(ra, rl, rb, 1'($urandom()), 1'b1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
